// File: rtl/inst_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : inst_data_mem_arbiter
//  Description : Shares one single-outstanding SRAM-like memory port between
//                the IF-stage instruction fetch (inst_*) and the MEM-stage
//                data access (data_*). Round-robin grant on contention; each
//                granted request is carried through a small transaction FSM
//                (IDLE -> ADDR -> WAIT -> DONE) until its data_ok pulse.
//  Ports       : clk, resetn          - clock, asynchronous active-low reset
//                inst_req/addr        - fetch request (held until inst_data_ok)
//                inst_rdata/data_ok   - registered fetch data, completion pulse
//                data_req/wen/addr/wdata - load/store request (wen==0 is read)
//                data_rdata/data_ok   - registered load data, completion pulse
//                stallreq_if/mem      - combinational stall requests
//                mem_req/wen/addr/wdata - memory request (fields 0 when idle)
//                mem_addr_ok/data_ok/rdata - memory handshake and read data
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_data_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  inst_req,
    input  logic [ADDR_W-1:0]     inst_addr,
    output logic [DATA_W-1:0]     inst_rdata,
    output logic                  inst_data_ok,
    input  logic                  data_req,
    input  logic [DATA_W/8-1:0]   data_wen,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    output logic [DATA_W-1:0]     data_rdata,
    output logic                  data_data_ok,
    output logic                  stallreq_if,
    output logic                  stallreq_mem,
    output logic                  mem_req,
    output logic [DATA_W/8-1:0]   mem_wen,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_addr_ok,
    input  logic                  mem_data_ok,
    input  logic [DATA_W-1:0]     mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic c_OWNER_INST = 1'b0;
    localparam logic c_OWNER_DATA = 1'b1;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_owner;
    logic                    r_last_owner;
    logic [DATA_W/8-1:0]     r_wen;
    logic [ADDR_W-1:0]       r_addr;
    logic [DATA_W-1:0]       r_wdata;
    logic [DATA_W-1:0]       r_inst_rdata;
    logic [DATA_W-1:0]       r_data_rdata;

    logic                    w_grant;
    logic                    w_grant_data;
    logic                    w_complete;

    // Next-state logic. On a tie the requester that did not own the last
    // completed transaction wins; last_owner resets to INST so the first tie
    // goes to DATA.
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_grant_data = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (inst_req || data_req) begin
                    w_grant      = 1'b1;
                    w_grant_data = data_req &&
                                   (!inst_req || (r_last_owner == c_OWNER_INST));
                    w_next_state = S_ADDR;
                end
            end
            S_ADDR: begin
                // data_ok without addr_ok cannot belong to this request
                if (mem_addr_ok) begin
                    if (mem_data_ok) begin
                        w_complete   = 1'b1;
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_data_ok) begin
                    w_complete   = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                // One-cycle bubble: the owner updates its request only after
                // seeing data_ok, so no grant is made here.
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_owner      <= c_OWNER_INST;
            r_last_owner <= c_OWNER_INST;
            r_wen        <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant) begin
                r_owner <= w_grant_data;
                if (w_grant_data) begin
                    r_wen   <= data_wen;
                    r_addr  <= data_addr;
                    r_wdata <= data_wdata;
                end else begin
                    r_wen   <= '0;
                    r_addr  <= inst_addr;
                    r_wdata <= '0;
                end
            end
            // Writes leave the owner's read-data register untouched.
            if (w_complete && (r_wen == '0)) begin
                if (r_owner == c_OWNER_DATA) begin
                    r_data_rdata <= mem_rdata;
                end else begin
                    r_inst_rdata <= mem_rdata;
                end
            end
            if (r_state == S_DONE) begin
                r_last_owner <= r_owner;
            end
        end
    end

    assign mem_req      = (r_state == S_ADDR);
    assign mem_wen      = mem_req ? r_wen   : '0;
    assign mem_addr     = mem_req ? r_addr  : '0;
    assign mem_wdata    = mem_req ? r_wdata : '0;

    assign inst_rdata   = r_inst_rdata;
    assign data_rdata   = r_data_rdata;
    assign inst_data_ok = (r_state == S_DONE) && (r_owner == c_OWNER_INST);
    assign data_data_ok = (r_state == S_DONE) && (r_owner == c_OWNER_DATA);

    // A requester stops stalling in the very cycle its data_ok is presented.
    assign stallreq_if  = inst_req && !inst_data_ok;
    assign stallreq_mem = data_req && !data_data_ok;

endmodule
`default_nettype wire
